// File: rtl/reg_wb_buffer.sv
// reg_wb_buffer
//   Register writeback buffer. Writeback requests are queued in order in a
//   small FIFO of {addr, val}. The FIFO drains into the register file write
//   port whenever the register file accepts a write. Read ports see pending
//   writes through combinational forwarding from the newest matching entry.
//
// Ports
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_wb_valid / o_wb_ready          writeback request handshake
//   i_wb_addr, i_wb_val              writeback destination and data
//   i_drain_en                       register file can take a write this cycle
//   o_reg_addr_w, o_reg_val_w        head entry presented to the write port
//   o_write_en                       register file write strobe
//   i_reg_{a,b}_addr_r               read addresses (also go to the register file)
//   i_reg_{a,b}_r                    raw register file read data
//   o_reg_{a,b}_r                    read data with pending writes forwarded
//   o_fwd_{a,b}_hit                  forwarded value selected
//   o_count                          occupied entries
module reg_wb_buffer #(
  parameter int REG_WIDTH       = 32,
  parameter int REG_ADDR_LENGTH = 8,
  parameter int DEPTH           = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wb_valid,
  output logic                       o_wb_ready,
  input  logic [REG_ADDR_LENGTH-1:0] i_wb_addr,
  input  logic [REG_WIDTH-1:0]       i_wb_val,
  input  logic                       i_drain_en,
  output logic [REG_ADDR_LENGTH-1:0] o_reg_addr_w,
  output logic [REG_WIDTH-1:0]       o_reg_val_w,
  output logic                       o_write_en,
  input  logic [REG_ADDR_LENGTH-1:0] i_reg_a_addr_r,
  input  logic [REG_ADDR_LENGTH-1:0] i_reg_b_addr_r,
  input  logic [REG_WIDTH-1:0]       i_reg_a_r,
  input  logic [REG_WIDTH-1:0]       i_reg_b_r,
  output logic [REG_WIDTH-1:0]       o_reg_a_r,
  output logic [REG_WIDTH-1:0]       o_reg_b_r,
  output logic                       o_fwd_a_hit,
  output logic                       o_fwd_b_hit,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entries are held in flops rather than block RAM: forwarding must
  // compare every occupied entry against both read addresses in parallel.
  logic [REG_ADDR_LENGTH-1:0] addr_mem [DEPTH];
  logic [REG_WIDTH-1:0]       val_mem  [DEPTH];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic push;
  logic pop;

  // Ready depends only on registered occupancy, so a full buffer refuses a
  // request even in a cycle where it is draining.
  assign o_wb_ready   = (count_reg < CNT_W'(DEPTH));
  assign o_write_en   = (count_reg != '0) && i_drain_en;
  assign push         = i_wb_valid && o_wb_ready;
  assign pop          = o_write_en;
  assign o_reg_addr_w = addr_mem[head_reg];
  assign o_reg_val_w  = val_mem[head_reg];
  assign o_count      = count_reg;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      addr_mem[tail_reg] <= i_wb_addr;
      val_mem[tail_reg]  <= i_wb_val;
    end
  end

  // Slot gi is the gi-th oldest entry counted from the head. The head stays
  // live during the cycle it is popped because occupancy only drops at the
  // edge; an entry being pushed is not live until the following cycle.
  logic [PTR_W-1:0] slot_idx [DEPTH];
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_idx[gi] = head_reg + PTR_W'(gi);
    assign live[gi]     = (CNT_W'(gi) < count_reg);
    assign match_a[gi]  = live[gi] && (addr_mem[slot_idx[gi]] == i_reg_a_addr_r);
    assign match_b[gi]  = live[gi] && (addr_mem[slot_idx[gi]] == i_reg_b_addr_r);
  end

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    o_reg_a_r   = i_reg_a_r;
    o_fwd_a_hit = 1'b0;
    o_reg_b_r   = i_reg_b_r;
    o_fwd_b_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_a[k]) begin
        o_reg_a_r   = val_mem[slot_idx[k]];
        o_fwd_a_hit = 1'b1;
      end
      if (match_b[k]) begin
        o_reg_b_r   = val_mem[slot_idx[k]];
        o_fwd_b_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_buffer.sv
// tb_reg_wb_buffer
//   Directed bench for reg_wb_buffer (default parameters). A queue holds the
//   pending writes the bench expects; entries are pushed when a request is
//   accepted and popped and compared when the DUT strobes a write. The same
//   queue supplies the expected forwarded read values.
module tb_reg_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        o_wb_ready;
  logic [7:0]  wb_addr;
  logic [31:0] wb_val;
  logic        drain_en;
  logic [7:0]  o_reg_addr_w;
  logic [31:0] o_reg_val_w;
  logic        o_write_en;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic [31:0] rar;
  logic [31:0] rbr;
  logic [31:0] o_reg_a_r;
  logic [31:0] o_reg_b_r;
  logic        o_fwd_a_hit;
  logic        o_fwd_b_hit;
  logic [2:0]  o_count;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] v;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  reg_wb_buffer #(.REG_WIDTH(32), .REG_ADDR_LENGTH(8), .DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wb_valid     (wb_valid),
    .o_wb_ready     (o_wb_ready),
    .i_wb_addr      (wb_addr),
    .i_wb_val       (wb_val),
    .i_drain_en     (drain_en),
    .o_reg_addr_w   (o_reg_addr_w),
    .o_reg_val_w    (o_reg_val_w),
    .o_write_en     (o_write_en),
    .i_reg_a_addr_r (ra),
    .i_reg_b_addr_r (rb),
    .i_reg_a_r      (rar),
    .i_reg_b_r      (rbr),
    .o_reg_a_r      (o_reg_a_r),
    .o_reg_b_r      (o_reg_b_r),
    .o_fwd_a_hit    (o_fwd_a_hit),
    .o_fwd_b_hit    (o_fwd_b_hit),
    .o_count        (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest pending entry with a matching address, else the raw value.
  task automatic fwd(input logic [7:0] ad, input logic [31:0] raw,
                     output logic [31:0] val, output logic hit);
    val = raw;
    hit = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].a == ad) begin
        val = sb[i].v;
        hit = 1'b1;
        break;
      end
    end
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks the
  // settled outputs, updates the expected queue, returns at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] wa, input logic [31:0] wv,
                       input logic d);
    logic [31:0] ea, eb;
    logic        ha, hb;
    logic        exp_we, exp_rdy;
    ent_t        e;
    wb_valid = v;
    wb_addr  = wa;
    wb_val   = wv;
    drain_en = d;
    #1;
    exp_rdy = (sb.size() < DEPTH);
    exp_we  = (sb.size() != 0) && d;
    chk("count",    64'(o_count),    64'(sb.size()));
    chk("wb_ready", 64'(o_wb_ready), 64'(exp_rdy));
    chk("write_en", 64'(o_write_en), 64'(exp_we));
    fwd(ra, rar, ea, ha);
    fwd(rb, rbr, eb, hb);
    chk("reg_a_r",   64'(o_reg_a_r),   64'(ea));
    chk("fwd_a_hit", 64'(o_fwd_a_hit), 64'(ha));
    chk("reg_b_r",   64'(o_reg_b_r),   64'(eb));
    chk("fwd_b_hit", 64'(o_fwd_b_hit), 64'(hb));
    if (exp_we) begin
      chk("wr_addr", 64'(o_reg_addr_w), 64'(sb[0].a));
      chk("wr_val",  64'(o_reg_val_w),  64'(sb[0].v));
      $display("write addr=%02h val=%08h count=%0d", o_reg_addr_w, o_reg_val_w, o_count);
      void'(sb.pop_front());
    end
    if (v && exp_rdy) begin
      e.a = wa;
      e.v = wv;
      sb.push_back(e);
      $display("push  addr=%02h val=%08h", wa, wv);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held across an edge with a request present: nothing is accepted.
    rst = 1'b1; wb_valid = 1'b1; wb_addr = 8'h42; wb_val = 32'h1234_5678;
    drain_en = 1'b1; ra = 8'h42; rb = 8'h42; rar = 32'h77; rbr = 32'h88;
    @(negedge clk);
    chk("rst_count",  64'(o_count),     64'd0);
    chk("rst_ready",  64'(o_wb_ready),  64'd1);
    chk("rst_we",     64'(o_write_en),  64'd0);
    chk("rst_hit_a",  64'(o_fwd_a_hit), 64'd0);
    chk("rst_hit_b",  64'(o_fwd_b_hit), 64'd0);
    chk("rst_pass_a", 64'(o_reg_a_r),   64'h77);
    chk("rst_pass_b", 64'(o_reg_b_r),   64'h88);
    rst = 1'b0;
    ra = 8'h00; rb = 8'h00;

    // Single push, hold, then drain.
    cycle(1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);
    cycle(1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);

    // Five back-to-back pushes into a depth-4 buffer, then drain in order.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i), 32'hA000_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);

    // Duplicate address: the newer value is forwarded until both drain.
    ra = 8'h03; rar = 32'h99;
    cycle(1'b1, 8'h03, 32'h11, 1'b0);
    cycle(1'b1, 8'h03, 32'h22, 1'b0);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);
    cycle(1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);

    // Full with drain and valid: refused push, one pop; then push+pop.
    ra = 8'h21;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i), 32'hB000_0000 + 32'(i), 1'b0);
    cycle(1'b1, 8'h30, 32'hC0, 1'b1);
    cycle(1'b1, 8'h31, 32'hC1, 1'b1);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 32'h0, 1'b1);

    // Request pushed this cycle is not forwarded until the next.
    rb = 8'h07; rbr = 32'h5;
    cycle(1'b1, 8'h07, 32'h44, 1'b0);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);

    // Mid-cycle reset with three pending entries.
    cycle(1'b1, 8'h08, 32'h80, 1'b0);
    cycle(1'b1, 8'h09, 32'h90, 1'b0);
    ra = 8'h09; rar = 32'h3;
    wb_valid = 1'b0; drain_en = 1'b1;
    #1;
    chk("pre_rst_count", 64'(o_count), 64'd3);
    rst = 1'b1;
    #1;
    chk("async_count", 64'(o_count),     64'd0);
    chk("async_we",    64'(o_write_en),  64'd0);
    chk("async_ready", 64'(o_wb_ready),  64'd1);
    chk("async_hit_a", 64'(o_fwd_a_hit), 64'd0);
    chk("async_pass",  64'(o_reg_a_r),   64'h3);
    sb.delete();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 32'h0, 1'b1);

    // Mixed traffic over a small address set.
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom_range(1, 3));
      rb  = 8'($urandom_range(1, 3));
      rar = $urandom;
      rbr = $urandom;
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)), $urandom,
            1'($urandom_range(0, 1)));
    end
    while (sb.size() != 0) cycle(1'b0, 8'h00, 32'h0, 1'b1);
    cycle(1'b0, 8'h00, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_wb_buffer.md
REG_WB_BUFFER -- requirements
Module: reg_wb_buffer

Interface
- REQ-001: Parameter REG_WIDTH, default 32, register data width.
- REQ-002: Parameter REG_ADDR_LENGTH, default 8, register address width.
- REQ-003: Parameter DEPTH, default 4, pending-write entries; power of two, 2..16.
- REQ-004: i_clk  in  1  sole clock; all state updates on its rising edge.
- REQ-005: i_rst  in  1  reset, asynchronous and active-high.
- REQ-006: i_wb_valid  in  1  upstream writeback request valid.
- REQ-007: o_wb_ready  out  1  buffer can accept a request this cycle.
- REQ-008: i_wb_addr  in  REG_ADDR_LENGTH  writeback destination register.
- REQ-009: i_wb_val  in  REG_WIDTH  writeback data.
- REQ-010: i_drain_en  in  1  register file accepts a write this cycle.
- REQ-011: o_reg_addr_w  out  REG_ADDR_LENGTH  head-entry address to the register file write port.
- REQ-012: o_reg_val_w  out  REG_WIDTH  head-entry data to the register file write port.
- REQ-013: o_write_en  out  1  register file write strobe.
- REQ-014: i_reg_a_addr_r, i_reg_b_addr_r  in  REG_ADDR_LENGTH each  read addresses, also driven to the register file.
- REQ-015: i_reg_a_r, i_reg_b_r  in  REG_WIDTH each  raw register file read data for those addresses.
- REQ-016: o_reg_a_r, o_reg_b_r  out  REG_WIDTH each  read data with pending writes forwarded.
- REQ-017: o_fwd_a_hit, o_fwd_b_hit  out  1 each  forwarded value selected for port a / b.
- REQ-018: o_count  out  $clog2(DEPTH)+1  occupied entries.

Function
- REQ-019: The buffer SHALL be an in-order FIFO of {addr, val} with head/tail pointers wrapping modulo DEPTH.
- REQ-020: Push SHALL occur at a rising edge when i_wb_valid && o_wb_ready; i_wb_addr/i_wb_val are ignored otherwise.
- REQ-021: o_wb_ready SHALL equal (o_count < DEPTH), registered-state only, with no combinational path from i_drain_en.
- REQ-022: o_write_en SHALL equal (o_count != 0) && i_drain_en; o_reg_addr_w/o_reg_val_w SHALL present the head entry whenever o_count != 0.
- REQ-023: Pop SHALL occur at a rising edge when o_write_en is 1; one write per cycle maximum.
- REQ-024: Simultaneous push and pop SHALL leave o_count unchanged; push alone increments it, pop alone decrements it.
- REQ-025: Minimum latency from push edge to o_write_en SHALL be one cycle (entry visible the cycle after acceptance); no same-cycle bypass of an incoming request to the write port.
- REQ-026: When full (o_count == DEPTH), o_wb_ready SHALL be 0 even if a pop occurs that cycle.
- REQ-027: When empty, o_write_en SHALL be 0 regardless of i_drain_en; o_reg_addr_w/o_reg_val_w are don't-care.
- REQ-028: Forwarding SHALL be combinational: o_reg_a_r equals the val of the newest (closest to tail) occupied entry whose addr equals i_reg_a_addr_r, else i_reg_a_r; likewise for port b.
- REQ-029: The head entry SHALL remain a forwarding candidate in the cycle it is popped.
- REQ-030: A request being pushed in the current cycle SHALL NOT be forwarded until the following cycle.
- REQ-031: o_fwd_a_hit/o_fwd_b_hit SHALL be 1 exactly when REQ-028 selects a buffered value.
- REQ-032: Duplicate addresses SHALL be retained and written in push order; no coalescing.

Reset
- REQ-033: Asserting i_rst SHALL immediately clear pointers and o_count to 0, giving o_wb_ready=1, o_write_en=0, o_fwd_a_hit=o_fwd_b_hit=0; o_reg_a_r/o_reg_b_r pass through i_reg_a_r/i_reg_b_r.
- REQ-034: Pending entries at reset SHALL be discarded unwritten; entry storage needs no reset.
- REQ-035: No push or pop SHALL occur on an edge where i_rst is 1; normal operation resumes on the first edge after deassertion.

Verification
- REQ-036: Reset, then push (0x05, 0xDEADBEEF) with i_drain_en=0 -> o_count=1; next cycle o_write_en=0; raising i_drain_en -> o_write_en=1, addr 0x05, val 0xDEADBEEF, o_count=0 after the edge.
- REQ-037: DEPTH=4, i_drain_en=0, push 5 back-to-back -> o_wb_ready falls after the 4th push, 5th held off, o_count=4; drain 4 cycles -> writes in push order.
- REQ-038: Push (0x03,0x11) then (0x03,0x22), read a=0x03, i_reg_a_r=0x99 -> o_reg_a_r=0x22, o_fwd_a_hit=1; after both drain -> o_reg_a_r=0x99, hit=0.
- REQ-039: Full buffer with i_drain_en=1 and i_wb_valid=1 -> o_wb_ready=0 that cycle, one pop, o_count=3; next cycle push and pop together -> o_count stays 3.
- REQ-040: Read b=0x07 in the same cycle (0x07,0x44) is pushed into an empty buffer -> o_fwd_b_hit=0 that cycle, 1 the next.
- REQ-041: Assert i_rst mid-cycle with o_count=3 -> o_count=0, o_write_en=0 without a clock edge; subsequent drain produces no writes.
